// File: rtl/vga_pkg.sv
// Shared definitions for the VGA generators: 640x480@60 timing defaults,
// per-axis direction encodings and the line/frame total helper.
package vga_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    typedef enum logic {DIREITA, ESQUERDA} dir_x_t;
    typedef enum logic {BAIXO, CIMA} dir_y_t;

    // Total pixels per line or lines per frame.
    function automatic int unsigned vga_total(input int unsigned active,
                                              input int unsigned fp,
                                              input int unsigned sync,
                                              input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_temporizador.sv
// VGA timing core: raw pixel/line counters plus combinational syncs,
// data-enable and the end-of-last-active-line strobe.
// Ports: clock, reset (sync, active-high); sx/sy counters;
//        hsync_c/vsync_c (active-low), de_c, fim_ativo_c (combinational).
module vga_temporizador
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP
) (
    input  logic                                                      clock,
    input  logic                                                      reset,
    output logic [$clog2(vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP))-1:0] sx,
    output logic [$clog2(vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP))-1:0] sy,
    output logic                                                      hsync_c,
    output logic                                                      vsync_c,
    output logic                                                      de_c,
    output logic                                                      fim_ativo_c
);

    localparam int unsigned H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned SXW     = $clog2(H_TOTAL);
    localparam int unsigned SYW     = $clog2(V_TOTAL);

    logic [31:0] sx32;
    logic [31:0] sy32;

    // Pixel counter wraps per line; line counter advances on each wrap.
    always_ff @(posedge clock) begin
        if (reset) begin
            sx <= '0;
            sy <= '0;
        end else if (sx == SXW'(H_TOTAL - 1)) begin
            sx <= '0;
            if (sy == SYW'(V_TOTAL - 1)) sy <= '0;
            else                         sy <= sy + SYW'(1);
        end else begin
            sx <= sx + SXW'(1);
        end
    end

    // Compare in 32 bits so sync windows ending at the total never alias.
    always_comb begin
        sx32        = 32'(sx);
        sy32        = 32'(sy);
        hsync_c     = !((sx32 >= H_ACTIVE + H_FP) && (sx32 < H_ACTIVE + H_FP + H_SYNC));
        vsync_c     = !((sy32 >= V_ACTIVE + V_FP) && (sy32 < V_ACTIVE + V_FP + V_SYNC));
        de_c        = (sx32 < H_ACTIVE) && (sy32 < V_ACTIVE);
        fim_ativo_c = (sx32 == H_TOTAL - 1) && (sy32 == V_ACTIVE - 1);
    end

endmodule

// File: rtl/quadrado_movel.sv
// VGA frame generator drawing a solid square that bounces off the screen
// edges over a flat background; position updates in vertical blanking.
// Ports: clock, reset (sync, active-high), pausa (freeze motion),
//        cor_frente/cor_fundo {r,g,b}; registered vga_hsync/vga_vsync
//        (active-low), vga_r/g/b, vga_blank, canto; raw counters sx/sy.
module quadrado_movel
    import vga_pkg::*;
#(
    parameter int unsigned COLOR_W   = 10,
    parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
    parameter int unsigned H_FP      = DEF_H_FP,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BP      = DEF_H_BP,
    parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
    parameter int unsigned V_FP      = DEF_V_FP,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BP      = DEF_V_BP,
    parameter int unsigned SIZE      = 200,
    parameter int unsigned STEP      = 2,
    parameter int unsigned FRAME_DIV = 1
) (
    input  logic                                                      clock,
    input  logic                                                      reset,
    input  logic                                                      pausa,
    input  logic [3*COLOR_W-1:0]                                      cor_frente,
    input  logic [3*COLOR_W-1:0]                                      cor_fundo,
    output logic                                                      vga_hsync,
    output logic                                                      vga_vsync,
    output logic [COLOR_W-1:0]                                        vga_r,
    output logic [COLOR_W-1:0]                                        vga_g,
    output logic [COLOR_W-1:0]                                        vga_b,
    output logic                                                      vga_blank,
    output logic [$clog2(vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP))-1:0] sx,
    output logic [$clog2(vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP))-1:0] sy,
    output logic                                                      canto
);

    localparam int unsigned XW    = $clog2(H_ACTIVE);
    localparam int unsigned YW    = $clog2(V_ACTIVE);
    localparam int unsigned MAX_X = H_ACTIVE - SIZE;
    localparam int unsigned MAX_Y = V_ACTIVE - SIZE;
    localparam int unsigned FW    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    logic hsync_c;
    logic vsync_c;
    logic de_c;
    logic fim_ativo_c;

    vga_temporizador #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_temporizador (
        .clock       (clock),
        .reset       (reset),
        .sx          (sx),
        .sy          (sy),
        .hsync_c     (hsync_c),
        .vsync_c     (vsync_c),
        .de_c        (de_c),
        .fim_ativo_c (fim_ativo_c)
    );

    dir_x_t          dir_x, dir_x_nxt;
    dir_y_t          dir_y, dir_y_nxt;
    logic [XW-1:0]   pos_x, pos_x_nxt;
    logic [YW-1:0]   pos_y, pos_y_nxt;
    logic [FW-1:0]   frame_cnt;
    logic            tick_c;
    logic            flip_x;
    logic            flip_y;
    logic            dentro_c;
    logic [3*COLOR_W-1:0] cor_c;
    logic [31:0]     sx32;
    logic [31:0]     sy32;
    logic [31:0]     px32;
    logic [31:0]     py32;

    // Frame divider advances every frame, paused or not.
    always_ff @(posedge clock) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (fim_ativo_c) begin
            if (frame_cnt == FW'(FRAME_DIV - 1)) frame_cnt <= '0;
            else                                 frame_cnt <= frame_cnt + FW'(1);
        end
    end

    assign tick_c = fim_ativo_c && (frame_cnt == FW'(FRAME_DIV - 1)) && !pausa;

    // Direction state and position registers for both axes.
    always_ff @(posedge clock) begin
        if (reset) begin
            dir_x <= DIREITA;
            dir_y <= BAIXO;
            pos_x <= XW'(MAX_X / 2);
            pos_y <= YW'(MAX_Y / 2);
            canto <= 1'b0;
        end else begin
            dir_x <= dir_x_nxt;
            dir_y <= dir_y_nxt;
            pos_x <= pos_x_nxt;
            pos_y <= pos_y_nxt;
            canto <= flip_x && flip_y;
        end
    end

    // Bounce next-state: clamp at the limit and reverse; compares carry one
    // extra bit so pos+STEP cannot overflow.
    always_comb begin
        dir_x_nxt = dir_x;
        dir_y_nxt = dir_y;
        pos_x_nxt = pos_x;
        pos_y_nxt = pos_y;
        flip_x    = 1'b0;
        flip_y    = 1'b0;
        if (tick_c) begin
            unique case (dir_x)
                DIREITA: begin
                    if (({1'b0, pos_x} + (XW+1)'(STEP)) >= (XW+1)'(MAX_X)) begin
                        pos_x_nxt = XW'(MAX_X);
                        dir_x_nxt = ESQUERDA;
                        flip_x    = 1'b1;
                    end else begin
                        pos_x_nxt = pos_x + XW'(STEP);
                    end
                end
                ESQUERDA: begin
                    if ({1'b0, pos_x} <= (XW+1)'(STEP)) begin
                        pos_x_nxt = '0;
                        dir_x_nxt = DIREITA;
                        flip_x    = 1'b1;
                    end else begin
                        pos_x_nxt = pos_x - XW'(STEP);
                    end
                end
                default: dir_x_nxt = DIREITA;
            endcase
            unique case (dir_y)
                BAIXO: begin
                    if (({1'b0, pos_y} + (YW+1)'(STEP)) >= (YW+1)'(MAX_Y)) begin
                        pos_y_nxt = YW'(MAX_Y);
                        dir_y_nxt = CIMA;
                        flip_y    = 1'b1;
                    end else begin
                        pos_y_nxt = pos_y + YW'(STEP);
                    end
                end
                CIMA: begin
                    if ({1'b0, pos_y} <= (YW+1)'(STEP)) begin
                        pos_y_nxt = '0;
                        dir_y_nxt = BAIXO;
                        flip_y    = 1'b1;
                    end else begin
                        pos_y_nxt = pos_y - YW'(STEP);
                    end
                end
                default: dir_y_nxt = BAIXO;
            endcase
        end
    end

    // Square membership over the full unsigned range, then pixel colour.
    always_comb begin
        sx32     = 32'(sx);
        sy32     = 32'(sy);
        px32     = 32'(pos_x);
        py32     = 32'(pos_y);
        dentro_c = (sx32 >= px32) && (sx32 < px32 + SIZE) &&
                   (sy32 >= py32) && (sy32 < py32 + SIZE);
        cor_c    = '0;
        if (de_c) cor_c = dentro_c ? cor_frente : cor_fundo;
    end

    // One register stage keeps syncs, blank and colour aligned.
    always_ff @(posedge clock) begin
        if (reset) begin
            vga_hsync <= 1'b1;
            vga_vsync <= 1'b1;
            vga_blank <= 1'b0;
            vga_r     <= '0;
            vga_g     <= '0;
            vga_b     <= '0;
        end else begin
            vga_hsync <= hsync_c;
            vga_vsync <= vsync_c;
            vga_blank <= de_c;
            vga_r     <= cor_c[3*COLOR_W-1:2*COLOR_W];
            vga_g     <= cor_c[2*COLOR_W-1:COLOR_W];
            vga_b     <= cor_c[COLOR_W-1:0];
        end
    end

endmodule

// File: tb/tb_quadrado_movel.sv
// Directed bench for quadrado_movel on a reduced 24x8 screen (32x12 totals),
// SIZE=4, STEP=2, FRAME_DIV=2, so X bounces at 20 and Y at 4.
module tb_quadrado_movel;

    localparam int unsigned CW = 4;
    localparam int unsigned HT = 32;
    localparam int unsigned VT = 12;

    logic            clock;
    logic            reset;
    logic            pausa;
    logic [3*CW-1:0] cor_frente;
    logic [3*CW-1:0] cor_fundo;
    logic            vga_hsync;
    logic            vga_vsync;
    logic [CW-1:0]   vga_r;
    logic [CW-1:0]   vga_g;
    logic [CW-1:0]   vga_b;
    logic            vga_blank;
    logic [4:0]      sx;
    logic [3:0]      sy;
    logic            canto;

    int checks = 0;
    int errors = 0;

    quadrado_movel #(
        .COLOR_W(CW), .H_ACTIVE(24), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SIZE(4), .STEP(2), .FRAME_DIV(2)
    ) dut (
        .clock(clock), .reset(reset), .pausa(pausa),
        .cor_frente(cor_frente), .cor_fundo(cor_fundo),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_blank(vga_blank), .sx(sx), .sy(sy), .canto(canto)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic verifica(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to the negedge where the counters show (px,py); bounded.
    task automatic vai_para(input int px, input int py);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 800; i++) begin
            @(negedge clock);
            if (int'(sx) == px && int'(sy) == py) begin
                ok = 1'b1;
                break;
            end
        end
        verifica("vai_para", 32'(ok), 32'd1);
    endtask

    function automatic logic [31:0] rgb();
        return 32'({vga_r, vga_g, vga_b});
    endfunction

    // Expected position after the strobe of frame f (updates on odd frames,
    // frames 11 and 13 paused).
    int exp_x [16] = '{10, 12, 12, 14, 14, 16, 16, 18, 18, 20, 20, 20, 20, 20, 20, 18};
    int exp_y [16] = '{ 2,  4,  4,  2,  2,  0,  0,  2,  2,  4,  4,  4,  4,  4,  4,  2};

    initial begin
        int cnt_err, hs_total, hs_line0, first_hs, vs_total, first_vs;
        int bl_line0, bl_total, cor_fora;
        int psx, psy, pp;
        logic [31:0] p_10_2, p_9_2, p_13_5, p_14_5, p_10_6, p_13_1;

        reset      = 1'b1;
        pausa      = 1'b0;
        cor_frente = 12'hA5C;
        cor_fundo  = 12'h31E;
        repeat (2) @(posedge clock);
        @(negedge clock);

        verifica("rst_sx",    32'(sx), 32'd0);
        verifica("rst_sy",    32'(sy), 32'd0);
        verifica("rst_pos_x", 32'(dut.pos_x), 32'd10);
        verifica("rst_pos_y", 32'(dut.pos_y), 32'd2);
        verifica("rst_hsync", 32'(vga_hsync), 32'd1);
        verifica("rst_vsync", 32'(vga_vsync), 32'd1);
        verifica("rst_blank", 32'(vga_blank), 32'd0);
        verifica("rst_rgb",   rgb(), 32'd0);
        verifica("rst_canto", 32'(canto), 32'd0);

        reset    = 1'b0;
        cnt_err  = 0; hs_total = 0; hs_line0 = 0; first_hs = -1;
        vs_total = 0; first_vs = -1; bl_line0 = 0; bl_total = 0; cor_fora = 0;
        p_10_2 = '1; p_9_2 = '1; p_13_5 = '1; p_14_5 = '1; p_10_6 = '1; p_13_1 = '1;

        // Frame 0: outputs at each negedge belong to the previous counter value.
        for (int k = 1; k <= int'(HT * VT); k++) begin
            @(negedge clock);
            pp  = k - 1;
            psx = pp % HT;
            psy = pp / HT;
            if (int'(sx) != (k % HT) || int'(sy) != ((k / HT) % VT)) cnt_err++;
            if (!vga_hsync) begin
                hs_total++;
                if (psy == 0) hs_line0++;
                if (first_hs < 0) first_hs = psx;
            end
            if (!vga_vsync) begin
                vs_total++;
                if (first_vs < 0) first_vs = psy;
            end
            if (vga_blank) begin
                bl_total++;
                if (psy == 0) bl_line0++;
            end
            if (psx >= 24 && rgb() != 0) cor_fora++;
            if (psx == 10 && psy == 2) p_10_2 = rgb();
            if (psx ==  9 && psy == 2) p_9_2  = rgb();
            if (psx == 13 && psy == 5) p_13_5 = rgb();
            if (psx == 14 && psy == 5) p_14_5 = rgb();
            if (psx == 10 && psy == 6) p_10_6 = rgb();
            if (psx == 13 && psy == 1) p_13_1 = rgb();
        end

        verifica("contadores",   32'(cnt_err),  32'd0);
        verifica("hs_inicio",    32'(first_hs), 32'd26);
        verifica("hs_largura",   32'(hs_line0), 32'd3);
        verifica("hs_total",     32'(hs_total), 32'd36);
        verifica("vs_linha",     32'(first_vs), 32'd9);
        verifica("vs_total",     32'(vs_total), 32'd64);
        verifica("blank_linha0", 32'(bl_line0), 32'd24);
        verifica("blank_total",  32'(bl_total), 32'd192);
        verifica("cor_fora",     32'(cor_fora), 32'd0);
        verifica("pix_10_2", p_10_2, 32'hA5C);
        verifica("pix_9_2",  p_9_2,  32'h31E);
        verifica("pix_13_5", p_13_5, 32'hA5C);
        verifica("pix_14_5", p_14_5, 32'h31E);
        verifica("pix_10_6", p_10_6, 32'h31E);
        verifica("pix_13_1", p_13_1, 32'h31E);

        // Frames 1..15: position after each end-of-active strobe.
        for (int f = 1; f < 16; f++) begin
            pausa = (f >= 10 && f <= 14);
            vai_para(31, 7);
            @(negedge clock);
            verifica($sformatf("pos_x_f%0d", f), 32'(dut.pos_x), 32'(exp_x[f]));
            verifica($sformatf("pos_y_f%0d", f), 32'(dut.pos_y), 32'(exp_y[f]));
            verifica($sformatf("canto_f%0d", f), 32'(canto), (f == 9) ? 32'd1 : 32'd0);
            if (f == 9) begin
                @(negedge clock);
                verifica("canto_1ciclo", 32'(canto), 32'd0);
            end
            if (f == 1) begin
                // New position visible from frame 2 with fresh colours.
                cor_frente = 12'h7F1;
                cor_fundo  = 12'h2B4;
                vai_para(11, 4);
                @(negedge clock);
                verifica("pix_11_4", rgb(), 32'h2B4);
                @(negedge clock);
                verifica("pix_12_4", rgb(), 32'h7F1);
            end
        end
        pausa = 1'b0;

        // Reset in the middle of an active line.
        vai_para(15, 3);
        reset = 1'b1;
        @(negedge clock);
        verifica("mrst_sx",    32'(sx), 32'd0);
        verifica("mrst_sy",    32'(sy), 32'd0);
        verifica("mrst_pos_x", 32'(dut.pos_x), 32'd10);
        verifica("mrst_pos_y", 32'(dut.pos_y), 32'd2);
        verifica("mrst_blank", 32'(vga_blank), 32'd0);
        verifica("mrst_rgb",   rgb(), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        verifica("mrst_sx_1",  32'(sx), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
